// File: rtl/uart_pkg.sv
// uart_pkg - definitions shared by the UART receive and transmit paths.
//   uart_state_e : 2-bit frame state (IDLE/START/DATA/STOP)
//   clks_per_bit : clock cycles per bit, truncated; used to size bit timers
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // clk_mhz is in MHz, baud in bit/s. Integer division truncates.
    function automatic int unsigned clks_per_bit(input int unsigned clk_mhz,
                                                 input int unsigned baud);
        return (clk_mhz * 32'd1000000) / baud;
    endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo - synchronous byte FIFO, first-word-fall-through.
//   clk, rst : clock and synchronous active-high reset
//   push/din : write request and byte; accepted if not full, or if full
//              while a pop happens in the same cycle
//   pop      : read request; ignored while empty
//   dout     : head byte; while empty, the last byte popped (00 after reset)
//   empty    : no bytes held
//   full     : DEPTH bytes held (judged before any same-cycle pop)
//   count    : bytes held, 0..DEPTH
module rx_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 din,
    input  logic                       pop,
    output logic [7:0]                 dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    last_q, last_d;
    logic          pop_ok, push_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);
    assign count = count_q;
    // Show the last popped byte while empty so dout never exposes a stale slot.
    assign dout  = empty ? last_q : mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can leave one unassigned and infer a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        pop_ok   = pop && !empty;
        // A pop in the same cycle frees the slot the push lands in (wr_ptr == rd_ptr when full).
        push_ok  = push && (!full || pop_ok);

        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            last_d   = mem_q[rd_ptr_q];
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= 8'h00;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    // NOTE: storage is deliberately not reset; dout only reads a slot after it has been written.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo - 8N1 UART receiver feeding a byte FIFO.
//   clk, rst  : clock and synchronous active-high reset
//   rx_pin    : asynchronous serial input, idle high
//   rd_en     : pop request; rd_data/rd_valid show the FIFO head
//   rx_count  : bytes currently buffered
//   overrun   : sticky, a good byte was dropped because the FIFO was full
//   frame_err : sticky, a stop bit was sampled low
//   err_clr   : clears both sticky flags (a same-cycle set wins)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FRE    = 27,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rx_pin,
    input  logic                            rd_en,
    output logic [7:0]                      rd_data,
    output logic                            rd_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
    output logic                            overrun,
    output logic                            frame_err,
    input  logic                            err_clr
);

    localparam int unsigned CPB  = clks_per_bit(CLK_FRE, BAUD_RATE);
    localparam int unsigned HALF = CPB / 2;
    localparam int          CYC_W = $clog2(CPB + 1);
    localparam logic [CYC_W-1:0] BIT_LAST  = CYC_W'(CPB - 1);
    localparam logic [CYC_W-1:0] HALF_LAST = CYC_W'(HALF - 1);
    localparam logic [1:0]       WARM_DONE = 2'd2;

    uart_state_e      state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             sync1_q, sync1_d, sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [1:0]       warm_q, warm_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;

    logic push, set_overrun, set_frame_err;
    logic fifo_empty, fifo_full, fifo_room;

    // Room exists if not full, or if the head is being popped this cycle.
    assign fifo_room = !fifo_full || (rd_en && !fifo_empty);

    always_comb begin
        sync1_d = rx_pin;
        sync2_d = sync1_q;
        // The synchronizer resets to 1, which is not a real observation of the line.
        // prev only follows the synced line once both flops hold pin samples, so a
        // line held low through reset never looks like a falling edge.
        warm_d  = (warm_q == WARM_DONE) ? warm_q : warm_q + 2'd1;
        prev_d  = (warm_q == WARM_DONE) ? sync2_q : 1'b0;

        state_d       = state_q;
        cyc_d         = cyc_q + 1'b1;
        bit_d         = bit_q;
        shift_d       = shift_q;
        push          = 1'b0;
        set_overrun   = 1'b0;
        set_frame_err = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cyc_d = '0;
                if (prev_q && !sync2_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cyc_q == HALF_LAST) begin
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cyc_q == BIT_LAST) begin
                    cyc_d          = '0;
                    shift_d[bit_q] = sync2_q;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (cyc_q == BIT_LAST) begin
                    cyc_d   = '0;
                    state_d = ST_IDLE;
                    if (!sync2_q) begin
                        set_frame_err = 1'b1;
                    end else if (fifo_room) begin
                        push = 1'b1;
                    end else begin
                        set_overrun = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        overrun_d   = set_overrun   | (overrun_q   & ~err_clr);
        frame_err_d = set_frame_err | (frame_err_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cyc_q       <= '0;
            bit_q       <= '0;
            shift_q     <= 8'h00;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b0;
            warm_q      <= 2'd0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            warm_q      <= warm_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    rx_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (shift_q),
        .pop   (rd_en),
        .dout  (rd_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (rx_count)
    );

    assign rd_valid  = !fifo_empty;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo - self-checking bench for uart_rx_fifo.
// A faster line rate keeps the run short: 27 MHz / 921600 baud -> 29 clocks per bit
// (a truncated, odd bit period), half bit = 14.
module tb_uart_rx_fifo;

    localparam int CLK_FRE   = 27;
    localparam int BAUD_RATE = 921600;
    localparam int DEPTH     = 8;
    localparam int CPB       = (CLK_FRE * 1000000) / BAUD_RATE;
    localparam int HALF      = CPB / 2;
    localparam int CW        = $clog2(DEPTH + 1);
    // Edges from the one after the pin falls to the edge that takes the stop sample:
    // two synchronizer flops, one edge-detect cycle, half a bit, eight bits, one stop bit.
    localparam int STOP_LAT  = 3 + HALF + 9 * CPB;
    localparam int GAP       = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_pin = 1'b1;
    logic          rd_en = 1'b0;
    logic          err_clr = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [CW-1:0] rx_count;
    logic          overrun;
    logic          frame_err;

    uart_rx_fifo #(
        .CLK_FRE    (CLK_FRE),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_pin    (rx_pin),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rx_count  (rx_count),
        .overrun   (overrun),
        .frame_err (frame_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        int         at;
        logic [7:0] data;
        logic       stop;
    } frame_t;

    int         errors = 0;
    int         checks = 0;
    int         edge_idx = 0;
    int         last_at = 0;
    bit         live = 1'b0;
    logic [7:0] mq[$];
    logic [7:0] m_last = 8'h00;
    bit         m_ovr = 1'b0;
    bit         m_fe = 1'b0;
    frame_t     pending[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_idx);
        end
    endtask

    // Model update at each rising edge: pops, frame completions, flags.
    initial begin
        frame_t ev;
        bit     set_o, set_f;
        forever begin
            @(posedge clk);
            edge_idx++;
            if (rst) begin
                mq.delete();
                pending.delete();
                m_last = 8'h00;
                m_ovr  = 1'b0;
                m_fe   = 1'b0;
                live   = 1'b1;
            end else begin
                set_o = 1'b0;
                set_f = 1'b0;
                if (rd_en && mq.size() > 0) m_last = mq.pop_front();
                while (pending.size() > 0 && pending[0].at <= edge_idx) begin
                    ev = pending.pop_front();
                    if (ev.at == edge_idx) begin
                        if (!ev.stop)               set_f = 1'b1;
                        else if (mq.size() < DEPTH) mq.push_back(ev.data);
                        else                        set_o = 1'b1;
                    end
                end
                m_ovr = set_o || (m_ovr && !err_clr);
                m_fe  = set_f || (m_fe && !err_clr);
            end
        end
    end

    // Every-cycle comparison, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (live) begin
                check("rd_valid",  32'(rd_valid),  32'(mq.size() > 0));
                check("rx_count",  32'(rx_count),  32'(mq.size()));
                check("rd_data",   32'(rd_data),   32'((mq.size() > 0) ? mq[0] : m_last));
                check("overrun",   32'(overrun),   32'(m_ovr));
                check("frame_err", 32'(frame_err), 32'(m_fe));
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", edge_idx);
        $fatal(1, "watchdog expired");
    end

    // ---------------- drivers (enter and leave just after a rising edge) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic clear_flags();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    // action: 0 none, 1 rd_en in the stop-sample cycle, 2 err_clr in the stop-sample cycle
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int action);
        logic [9:0] bits;
        frame_t     ev;
        bits    = {stop_bit, data, 1'b0};
        ev.at   = edge_idx + STOP_LAT;
        ev.data = data;
        ev.stop = stop_bit;
        last_at = ev.at;
        pending.push_back(ev);
        for (int b = 0; b < 10; b++) begin
            rx_pin = bits[b];
            for (int k = 0; k < CPB; k++) begin
                if (action == 1) rd_en   = (edge_idx == ev.at - 1);
                if (action == 2) err_clr = (edge_idx == ev.at - 1);
                step();
            end
        end
        rx_pin = 1'b1;
        if (action == 1) rd_en = 1'b0;
        if (action == 2) err_clr = 1'b0;
        repeat (GAP) step();
    endtask

    task automatic expect_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_count"}, 32'(rx_count), 32'd0);
        check({tag, "_data"},  32'(rd_data),  32'h00);
        check({tag, "_ovr"},   32'(overrun),  32'd0);
        check({tag, "_fe"},    32'(frame_err), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] d;
        int         act;
        logic       sb;

        rst = 1'b1;
        repeat (2) step();
        @(negedge clk);
        expect_reset_outputs("reset");
        step();
        rst = 1'b0;
        repeat (5) step();

        // 1. single byte, exact latency, then pop
        fork
            send_frame(8'hA5, 1'b1, 0);
            begin
                step();
                while (edge_idx < last_at - 1) step();
                @(negedge clk);
                check("t1_valid_in_stop_cycle", 32'(rd_valid), 32'd0);
                @(negedge clk);
                check("t1_valid_next_cycle", 32'(rd_valid), 32'd1);
                check("t1_data", 32'(rd_data), 32'hA5);
                check("t1_count", 32'(rx_count), 32'd1);
            end
        join
        pop_one();
        @(negedge clk);
        check("t1_valid_after_pop", 32'(rd_valid), 32'd0);
        check("t1_count_after_pop", 32'(rx_count), 32'd0);
        step();

        // 2. short low glitch shorter than half a bit
        rx_pin = 1'b0;
        repeat (HALF / 2) step();
        rx_pin = 1'b1;
        repeat (3 * CPB) step();
        @(negedge clk);
        check("t2_count", 32'(rx_count), 32'd0);
        check("t2_fe", 32'(frame_err), 32'd0);
        step();

        // 3. framing error, clear, then clear colliding with a new error
        send_frame(8'h3C, 1'b0, 0);
        @(negedge clk);
        check("t3_fe_set", 32'(frame_err), 32'd1);
        check("t3_count", 32'(rx_count), 32'd0);
        step();
        clear_flags();
        @(negedge clk);
        check("t3_fe_cleared", 32'(frame_err), 32'd0);
        step();
        send_frame(8'h3C, 1'b0, 2);
        @(negedge clk);
        check("t3_set_beats_clear", 32'(frame_err), 32'd1);
        step();

        // 4. overflow, ordered drain, then full push with simultaneous pop
        for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 0);
        @(negedge clk);
        check("t4_count_full", 32'(rx_count), 32'd8);
        check("t4_overrun", 32'(overrun), 32'd1);
        step();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t4_drain_order", 32'(rd_data), 32'(i));
            step();
            pop_one();
        end
        clear_flags();
        for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b1, 0);
        send_frame(8'h55, 1'b1, 1);
        @(negedge clk);
        check("t4_count_after_swap", 32'(rx_count), 32'd8);
        check("t4_no_overrun", 32'(overrun), 32'd0);
        step();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t4_swap_order", 32'(rd_data), (i == 7) ? 32'h55 : 32'(8'h11 + i));
            step();
            pop_one();
        end

        // 5. reset mid-frame with the line held low
        send_frame(8'h66, 1'b1, 0);
        send_frame(8'h99, 1'b0, 0);
        rx_pin = 1'b0;
        repeat (CPB) step();
        rx_pin = 1'b1;
        repeat (3 * CPB) step();
        rx_pin = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        expect_reset_outputs("t5_reset");
        step();
        repeat (4 * CPB) step();
        rx_pin = 1'b1;
        repeat (GAP) step();
        send_frame(8'h81, 1'b1, 0);
        @(negedge clk);
        check("t5_data", 32'(rd_data), 32'h81);
        check("t5_count", 32'(rx_count), 32'd1);
        step();

        // 6. pops on empty, push+pop at count 1, pointer wrap with random data
        pop_one();
        pop_one();
        pop_one();
        @(negedge clk);
        check("t6_empty_count", 32'(rx_count), 32'd0);
        check("t6_empty_hold", 32'(rd_data), 32'h81);
        step();
        send_frame(8'(32'($urandom_range(0, 255))), 1'b1, 0);
        send_frame(8'hC3, 1'b1, 1);
        @(negedge clk);
        check("t6_swap_head", 32'(rd_data), 32'hC3);
        check("t6_swap_count", 32'(rx_count), 32'd1);
        step();
        for (int i = 0; i < 16; i++) begin
            d   = 8'(32'($urandom_range(0, 255)));
            act = int'($urandom_range(0, 1));
            send_frame(d, 1'b1, act);
            if (act == 0) pop_one();
        end
        for (int i = 0; i < 8; i++) begin
            d   = 8'(32'($urandom_range(0, 255)));
            sb  = ($urandom_range(0, 3) != 0);
            act = int'($urandom_range(0, 2));
            send_frame(d, sb, act);
            repeat ($urandom_range(0, 2)) pop_one();
        end
        repeat (GAP) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
